// File: rtl/hash_rom_lookup.sv
// hash_rom_lookup: multiplicative-hash two 18-bit keys, look both up in a dual-port ROM, return tagged results through a credit-limited FWFT FIFO
// Ports: in_* request (valid/ready, two keys, tag); rom_addr_*/rom_q_* dual-port ROM read side; out_* result (valid/ready, two data words, tag)
module hash_rom_lookup #(
  parameter int          AWIDTH     = 12,
  parameter int          DWIDTH     = 16,
  parameter logic [17:0] MULT       = 18'h19E37,
  parameter int          RD_LATENCY = 2,
  parameter int          TAG_WIDTH  = 8,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [17:0]          in_key_a,
  input  logic [17:0]          in_key_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [AWIDTH-1:0]    rom_addr_a,
  output logic [AWIDTH-1:0]    rom_addr_b,
  input  logic [DWIDTH-1:0]    rom_q_a,
  input  logic [DWIDTH-1:0]    rom_q_b,
  output logic [DWIDTH-1:0]    out_data_a,
  output logic [DWIDTH-1:0]    out_data_b,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_valid,
  input  logic                 out_ready
);
  localparam int L  = 2 + RD_LATENCY;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 2;
  logic [17:0]          r_key_a, r_key_b;
  logic [AWIDTH-1:0]    r_addr_a, r_addr_b;
  logic [L-1:0]         r_vld;
  logic [TAG_WIDTH-1:0] r_tag [L];
  logic [DWIDTH-1:0]    r_mem_a [FIFO_DEPTH];
  logic [DWIDTH-1:0]    r_mem_b [FIFO_DEPTH];
  logic [TAG_WIDTH-1:0] r_mem_t [FIFO_DEPTH];
  logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]        r_inflight, r_count;
  logic                 w_acc, w_wr, w_pop;
  assign w_acc      = in_valid && in_ready;
  assign w_wr       = r_vld[L-1];
  assign w_pop      = out_valid && out_ready;
  assign in_ready   = (r_inflight + r_count) < CW'(FIFO_DEPTH);
  assign out_valid  = r_count != '0;
  assign rom_addr_a = r_addr_a;
  assign rom_addr_b = r_addr_b;
  assign out_data_a = out_valid ? r_mem_a[r_rd_ptr] : '0;
  assign out_data_b = out_valid ? r_mem_b[r_rd_ptr] : '0;
  assign out_tag    = out_valid ? r_mem_t[r_rd_ptr] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_key_a    <= '0;
      r_key_b    <= '0;
      r_addr_a   <= '0;
      r_addr_b   <= '0;
      r_vld      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_inflight <= '0;
      r_count    <= '0;
    end else begin
      r_key_a    <= in_key_a;
      r_key_b    <= in_key_b;
      r_addr_a   <= AWIDTH'((36'(r_key_a) * 36'(MULT)) >> (36 - AWIDTH));
      r_addr_b   <= AWIDTH'((36'(r_key_b) * 36'(MULT)) >> (36 - AWIDTH));
      r_vld      <= {r_vld[L-2:0], w_acc};
      r_wr_ptr   <= r_wr_ptr + PW'(w_wr);
      r_rd_ptr   <= r_rd_ptr + PW'(w_pop);
      r_inflight <= r_inflight + CW'(w_acc) - CW'(w_wr);
      r_count    <= r_count + CW'(w_wr) - CW'(w_pop);
    end
  always_ff @(posedge clk) begin
    r_tag[0] <= in_tag;
    for (int i = 1; i < L; i++) r_tag[i] <= r_tag[i-1];
    if (w_wr) begin
      r_mem_a[r_wr_ptr] <= rom_q_a;
      r_mem_b[r_wr_ptr] <= rom_q_b;
      r_mem_t[r_wr_ptr] <= r_tag[L-1];
    end
  end
  assert property (@(posedge clk) disable iff (rst) !(w_wr && r_count == CW'(FIFO_DEPTH)))
    else $error("hash_rom_lookup: result written into a full FIFO");
endmodule

// File: tb/tb_hash_rom_lookup.sv
// tb_hash_rom_lookup: scoreboard bench for hash_rom_lookup with behavioural ROMs at read latency 2 and 1
module tb_hash_rom_lookup;
  logic clk = 0, rst = 1;
  logic [17:0] in_key_a = '0, in_key_b = '0;
  logic [7:0]  in_tag = '0;
  logic        in_valid = 0, v1 = 0, out_ready = 0;
  logic        in_ready, out_valid, in_ready1, out_valid1;
  logic [11:0] rom_addr_a, rom_addr_b, rom_addr_a1, rom_addr_b1, ra_a, ra_b;
  logic [15:0] rom_q_a, rom_q_b, rom_q_a1, rom_q_b1;
  logic [15:0] out_data_a, out_data_b, out_data_a1, out_data_b1;
  logic [7:0]  out_tag, out_tag1;
  int checks = 0, errors = 0, acc = 0, pops = 0, gaps = 0, cyc = 0, last_pop = -10;
  logic [39:0] q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hash_rom_lookup dut (
    .clk(clk), .rst(rst), .in_key_a(in_key_a), .in_key_b(in_key_b), .in_tag(in_tag),
    .in_valid(in_valid), .in_ready(in_ready), .rom_addr_a(rom_addr_a), .rom_addr_b(rom_addr_b),
    .rom_q_a(rom_q_a), .rom_q_b(rom_q_b), .out_data_a(out_data_a), .out_data_b(out_data_b),
    .out_tag(out_tag), .out_valid(out_valid), .out_ready(out_ready));

  hash_rom_lookup #(.RD_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .in_key_a(in_key_a), .in_key_b(in_key_b), .in_tag(in_tag),
    .in_valid(v1), .in_ready(in_ready1), .rom_addr_a(rom_addr_a1), .rom_addr_b(rom_addr_b1),
    .rom_q_a(rom_q_a1), .rom_q_b(rom_q_b1), .out_data_a(out_data_a1), .out_data_b(out_data_b1),
    .out_tag(out_tag1), .out_valid(out_valid1), .out_ready(1'b1));

  function automatic logic [11:0] hash(input logic [17:0] k);
    logic [35:0] p;
    p = 36'(k) * 36'(18'h19E37);
    return p[35:24];
  endfunction

  function automatic logic [15:0] rom(input logic [11:0] a);
    return {a[3:0], a} ^ 16'h5A3C;
  endfunction

  always @(posedge clk) begin
    ra_a     <= rom_addr_a;
    ra_b     <= rom_addr_b;
    rom_q_a  <= rom(ra_a);
    rom_q_b  <= rom(ra_b);
    rom_q_a1 <= rom(rom_addr_a1);
    rom_q_b1 <= rom(rom_addr_b1);
  end

  task automatic check(input string name, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", name, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      pops++;
      if (cyc != last_pop + 1) gaps++;
      last_pop = cyc;
      check("sb_nonempty", 40'(q.size() > 0), 40'd1);
      if (q.size() > 0) check("result", {out_tag, out_data_a, out_data_b}, q.pop_front());
    end

  task automatic step();
    if (in_valid && in_ready) begin
      q.push_back({in_tag, rom(hash(in_key_a)), rom(hash(in_key_b))});
      acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 300) begin
      step();
      k++;
    end
    check("drain_empty", 40'(q.size()), 40'd0);
  endtask

  initial begin
    int lat0, lat1, drops, a0, p0, g0, stray;
    logic [39:0] seen1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 40'(in_ready), 40'd1);
    check("rst_out_valid", 40'(out_valid), 40'd0);
    check("rst_addr", {16'd0, rom_addr_a, rom_addr_b}, 40'd0);
    check("rst_out", {out_tag, out_data_a, out_data_b}, 40'd0);
    rst = 0;
    in_key_a = 18'h3FFFF; in_key_b = 18'h20000;
    step(); step();
    check("hash_ff_20", {16'd0, rom_addr_a, rom_addr_b}, {16'd0, 12'h678, 12'h33C});
    in_key_a = 18'h00000; in_key_b = 18'h3FFFF;
    step(); step();
    check("hash_00_ff", {16'd0, rom_addr_a, rom_addr_b}, {16'd0, 12'h000, 12'h678});
    in_key_a = 18'h20000; in_key_b = 18'h00000;
    step(); step();
    check("hash_20_00", {16'd0, rom_addr_a, rom_addr_b}, {16'd0, 12'h33C, 12'h000});
    in_key_a = 18'h12345; in_key_b = 18'h0ABCD; in_tag = 8'h5A;
    out_ready = 1; in_valid = 1; v1 = 1;
    step();
    in_valid = 0; v1 = 0; in_key_a = '0; in_key_b = '0; in_tag = '0;
    lat0 = 0; lat1 = 0; seen1 = '0;
    for (int c = 1; c < 20; c++) begin
      if (out_valid && lat0 == 0) lat0 = c;
      if (out_valid1 && lat1 == 0) begin
        lat1 = c;
        seen1 = {out_tag1, out_data_a1, out_data_b1};
      end
      step();
    end
    check("latency_rd2", 40'(lat0), 40'd5);
    check("latency_rd1", 40'(lat1), 40'd4);
    check("rd1_result", seen1, {8'h5A, rom(hash(18'h12345)), rom(hash(18'h0ABCD))});
    check("latency_drain", 40'(q.size()), 40'd0);
    drops = 0; p0 = pops; g0 = gaps; in_valid = 1;
    for (int i = 0; i < 100; i++) begin
      in_key_a = 18'($urandom); in_key_b = 18'($urandom); in_tag = 8'(i);
      if (!in_ready) drops++;
      step();
    end
    in_valid = 0;
    drain();
    check("stream_drops", 40'(drops), 40'd0);
    check("stream_count", 40'(pops - p0), 40'd100);
    check("stream_gaps", 40'(gaps - g0), 40'd1);
    out_ready = 0; in_valid = 1; a0 = acc;
    for (int i = 0; i < 20; i++) begin
      in_key_a = 18'($urandom); in_key_b = 18'($urandom); in_tag = 8'($urandom);
      step();
    end
    check("bp_accepted", 40'(acc - a0), 40'd8);
    check("bp_full_ready", 40'(in_ready), 40'd0);
    out_ready = 1;
    check("bp_pop_cycle_ready", 40'(in_ready), 40'd0);
    step();
    out_ready = 0;
    check("bp_after_pop_ready", 40'(in_ready), 40'd1);
    step();
    check("bp_refill_ready", 40'(in_ready), 40'd0);
    in_valid = 0;
    check("bp_total", 40'(acc - a0), 40'd9);
    out_ready = 1;
    drain();
    for (int i = 0; i < 10000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_key_a = 18'($urandom); in_key_b = 18'($urandom); in_tag = 8'($urandom);
      step();
    end
    in_valid = 0; out_ready = 1;
    drain();
    out_ready = 0; in_valid = 1;
    step(); step();
    in_valid = 0;
    repeat (6) step();
    check("mid_buffered", 40'(out_valid), 40'd1);
    in_valid = 1;
    step(); step(); step();
    in_valid = 0;
    #1 rst = 1;
    #1;
    check("mid_rst_out_valid", 40'(out_valid), 40'd0);
    check("mid_rst_in_ready", 40'(in_ready), 40'd1);
    q.delete();
    step();
    rst = 0; out_ready = 1; stray = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) stray++;
      step();
    end
    check("post_rst_stray", 40'(stray), 40'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
